// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_sub_16bit_fs_1bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module fs_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_sub_16bit.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output registered alongside D.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is high only in IDLE, out_valid only in DONE, so accept and release never share an edge.
module serial_sub_16bit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   D
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic             borrow_q;
  logic             bit_d, bit_bout;
  logic             last_bit;

  fs_1bit u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit  = (cnt_q == LAST_BIT);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right so bit 0 always feeds the subtractor; difference bits enter from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      borrow_q <= 1'b0;
      D        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          diff_sh  <= {bit_d, diff_sh[WIDTH-1:1]};
          borrow_q <= bit_bout;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) D <= {bit_bout, bit_d, diff_sh[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last bit the shifters hold the operand sign bits and bit_d is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf <= (a_sh[0] ^ b_sh[0]) & (bit_d ^ a_sh[0]);
    end
  end
`endif

endmodule

// File: doc/serial_sub_16bit.md
SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: in_valid  input  1  operands A, B, Bin are valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: A  input  WIDTH  minuend, unsigned.
REQ-007 Port: B  input  WIDTH  subtrahend, unsigned.
REQ-008 Port: Bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  D holds a completed result.
REQ-010 Port: out_ready  input  1  consumer accepts D.
REQ-011 Port: D  output  WIDTH+1  D[WIDTH-1:0] is the difference; D[WIDTH] is borrow-out.

Function
REQ-012 The block SHALL compute D[WIDTH-1:0] = (A - B - Bin) mod 2^WIDTH, with D[WIDTH] = 1 iff A < B + Bin (unsigned comparison).
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on a rising edge with in_valid=1, the block SHALL capture A, B and Bin into internal registers, clear the bit counter and enter RUN.
REQ-016 RUN: on each edge, the block SHALL process one bit, LSB first, using a 1-bit full subtractor whose borrow is registered between bits.
REQ-017 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE; out_valid SHALL therefore rise exactly WIDTH cycles after the accept edge.
REQ-018 DONE: D SHALL hold stable while out_ready=0; on an edge with out_ready=1, the FSM SHALL enter IDLE.
REQ-019 in_ready SHALL be 1 from the cycle after the output handshake; the block SHALL NOT accept input and release output on the same edge.
REQ-020 Changes to A, B, Bin or in_valid outside IDLE SHALL have no effect on the result in progress.
REQ-021 D SHALL be updated only at the RUN-to-DONE transition; it SHALL retain the last result in IDLE and RUN.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force: FSM to IDLE, counter = 0, internal borrow = 0, D = 0, out_valid = 0, in_ready = 1.
REQ-023 A reset asserted during RUN or DONE SHALL abort the operation; no out_valid pulse for that operation SHALL follow.
REQ-024 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN: when defined, the block SHALL add output port ovf (1 bit), set at the RUN-to-DONE transition to the two's-complement signed overflow of A - B - Bin (operand signs differ and the result sign differs from A's sign), reset to 0, and held like D.
REQ-026 When SERIAL_SUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the FSM state enum typedef (IDLE, RUN, DONE) and the default-width constant SUB_WIDTH_DEF = 16.
REQ-028 The bit-level datapath SHALL be a separate sub-module, fs_1bit (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-029 Operand registers SHALL be shift registers; no WIDTH-wide combinational subtractor SHALL be present.

Verification
REQ-030 A=0x0000, B=0x0000, Bin=0 -> out_valid 16 cycles after accept, D=0x00000.
REQ-031 A=0x0000, B=0x0001, Bin=0 -> D=0x1FFFF (borrow-out=1).
REQ-032 A=0xFFFF, B=0xFFFF, Bin=1 -> D=0x1FFFF; A=0xD431, B=0x3039, Bin=1 -> D=0x0A3F7.
REQ-033 Result 0x1234 with out_ready held 0 for 5 cycles -> D and out_valid stable, in_ready=0, in_valid pulses ignored; handshake, then in_ready=1 on the next cycle.
REQ-034 rst_n pulled low after 7 bits have been processed -> out_valid=0 and in_ready=1 immediately; no result is emitted; the next operation is correct.
REQ-035 With SERIAL_SUB_OVF_EN defined: A=0x8000, B=0x0001, Bin=0 -> D=0x07FFF, ovf=1; A=0x0005, B=0x0003 -> ovf=0.
